// File: rtl/v7_peak_detector.sv
// Peak detector for the variant-7 trapezoidal filter: finds threshold-crossing pulses,
// tracks amplitude/time/width with hysteresis pile-up detection, emits one event per pulse.
module v7_peak_detector #(
    parameter int SIZE_FILTER_DATA = 16,
    parameter int TS_W             = 32,
    parameter int HYST             = 16,
    parameter int HOLDOFF          = 4,
    parameter int MAX_WIDTH        = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [SIZE_FILTER_DATA-1:0] filter_data,
    input  logic [SIZE_FILTER_DATA-1:0] threshold,
    output logic                        peak_valid,
    input  logic                        peak_ready,
    output logic [SIZE_FILTER_DATA-1:0] peak_amp,
    output logic [TS_W-1:0]             peak_time,
    output logic [7:0]                  peak_width,
    output logic [1:0]                  peak_flags,
    output logic [15:0]                 lost_count
);

    localparam int DW = SIZE_FILTER_DATA;
    localparam int EW = SIZE_FILTER_DATA + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RISE = 3'd1,
        S_FALL = 3'd2,
        S_EMIT = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [TS_W-1:0]      ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0]      ts_q, ts_d;
    logic [TS_W-1:0]      max_ts_q, max_ts_d;
    logic signed [DW-1:0] x_q, x_d;
    logic signed [DW-1:0] x_prev_q, x_prev_d;
    logic signed [DW-1:0] max_q, max_d;
    logic signed [DW-1:0] min_q, min_d;
    logic [7:0]           width_q, width_d;
    logic [7:0]           hold_q, hold_d;
    logic [1:0]           flags_q, flags_d;
    logic                 peak_valid_q, peak_valid_d;
    logic [DW-1:0]        peak_amp_q, peak_amp_d;
    logic [TS_W-1:0]      peak_time_q, peak_time_d;
    logic [7:0]           peak_width_q, peak_width_d;
    logic [1:0]           peak_flags_q, peak_flags_d;
    logic [15:0]          lost_q, lost_d;

    logic signed [DW-1:0] thr_s;
    logic signed [EW-1:0] x_ext_s;
    logic signed [EW-1:0] fall_lvl_s;
    logic signed [EW-1:0] rise_lvl_s;
    logic                 above_s;
    logic                 cross_s;
    logic                 new_max_s;
    logic                 timeout_s;
    logic                 slot_free_s;
    logic [7:0]           width_inc_s;

    // Hysteresis levels are widened by one bit so max-HYST / min+HYST never wrap.
    always_comb begin
        thr_s       = $signed(threshold);
        x_ext_s     = $signed({x_q[DW-1], x_q});
        fall_lvl_s  = $signed({max_q[DW-1], max_q}) - $signed(EW'(HYST));
        rise_lvl_s  = $signed({min_q[DW-1], min_q}) + $signed(EW'(HYST));
        above_s     = (x_q > thr_s);
        cross_s     = (x_prev_q <= thr_s) && above_s;
        new_max_s   = (x_q > max_q);
        width_inc_s = width_q + 8'd1;
        timeout_s   = (width_inc_s == 8'(MAX_WIDTH));
        slot_free_s = !peak_valid_q || peak_ready;
    end

    // Next-state logic for the pulse FSM, sample pipeline and output slot.
    always_comb begin
        state_d      = state_q;
        ts_cnt_d     = ts_cnt_q + TS_W'(1);
        ts_d         = ts_cnt_q;
        x_d          = $signed(filter_data);
        x_prev_d     = x_q;
        max_d        = max_q;
        max_ts_d     = max_ts_q;
        min_d        = min_q;
        width_d      = width_q;
        hold_d       = hold_q;
        flags_d      = flags_q;
        peak_amp_d   = peak_amp_q;
        peak_time_d  = peak_time_q;
        peak_width_d = peak_width_q;
        peak_flags_d = peak_flags_q;
        lost_d       = lost_q;
        if (peak_valid_q && peak_ready) begin
            peak_valid_d = 1'b0;
        end else begin
            peak_valid_d = peak_valid_q;
        end

        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cross_s) begin
                        state_d  = S_RISE;
                        max_d    = x_q;
                        max_ts_d = ts_q;
                        width_d  = 8'd1;
                        flags_d  = 2'b00;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RISE: begin
                    if (new_max_s) begin
                        max_d    = x_q;
                        max_ts_d = ts_q;
                    end else begin
                        max_d    = max_q;
                        max_ts_d = max_ts_q;
                    end
                    if (!above_s) begin
                        state_d = S_EMIT;
                    end else begin
                        width_d = width_inc_s;
                        if (timeout_s) begin
                            flags_d[1] = 1'b1;
                            state_d    = S_EMIT;
                        end else if (x_ext_s <= fall_lvl_s) begin
                            min_d   = x_q;
                            state_d = S_FALL;
                        end else begin
                            state_d = S_RISE;
                        end
                    end
                end
                S_FALL: begin
                    if (!above_s) begin
                        state_d = S_EMIT;
                    end else begin
                        width_d = width_inc_s;
                        if (x_ext_s >= rise_lvl_s) begin
                            flags_d[0] = 1'b1;
                            if (new_max_s) begin
                                max_d    = x_q;
                                max_ts_d = ts_q;
                            end else begin
                                max_d    = max_q;
                                max_ts_d = max_ts_q;
                            end
                        end else if (x_q < min_q) begin
                            min_d = x_q;
                        end else begin
                            min_d = min_q;
                        end
                        if (timeout_s) begin
                            flags_d[1] = 1'b1;
                            state_d    = S_EMIT;
                        end else if (x_ext_s >= rise_lvl_s) begin
                            state_d = S_RISE;
                        end else begin
                            state_d = S_FALL;
                        end
                    end
                end
                S_EMIT: begin
                    if (slot_free_s) begin
                        peak_valid_d = 1'b1;
                        peak_amp_d   = max_q;
                        peak_time_d  = max_ts_q;
                        peak_width_d = width_q;
                        peak_flags_d = flags_q;
                    end else if (lost_q != 16'hFFFF) begin
                        lost_d = lost_q + 16'd1;
                    end else begin
                        lost_d = lost_q;
                    end
                    hold_d  = 8'd0;
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (hold_q >= 8'(HOLDOFF - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        hold_d  = hold_q + 8'd1;
                        state_d = S_HOLD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ts_cnt_q     <= '0;
            ts_q         <= '0;
            x_q          <= '0;
            x_prev_q     <= '0;
            max_q        <= '0;
            max_ts_q     <= '0;
            min_q        <= '0;
            width_q      <= 8'd0;
            hold_q       <= 8'd0;
            flags_q      <= 2'b00;
            peak_valid_q <= 1'b0;
            peak_amp_q   <= '0;
            peak_time_q  <= '0;
            peak_width_q <= 8'd0;
            peak_flags_q <= 2'b00;
            lost_q       <= 16'd0;
        end else begin
            state_q      <= state_d;
            ts_cnt_q     <= ts_cnt_d;
            ts_q         <= ts_d;
            x_q          <= x_d;
            x_prev_q     <= x_prev_d;
            max_q        <= max_d;
            max_ts_q     <= max_ts_d;
            min_q        <= min_d;
            width_q      <= width_d;
            hold_q       <= hold_d;
            flags_q      <= flags_d;
            peak_valid_q <= peak_valid_d;
            peak_amp_q   <= peak_amp_d;
            peak_time_q  <= peak_time_d;
            peak_width_q <= peak_width_d;
            peak_flags_q <= peak_flags_d;
            lost_q       <= lost_d;
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_amp   = peak_amp_q;
    assign peak_time  = peak_time_q;
    assign peak_width = peak_width_q;
    assign peak_flags = peak_flags_q;
    assign lost_count = lost_q;

endmodule

// File: tb/tb_v7_peak_detector.sv
// Bench for v7_peak_detector: directed pulses plus a randomized stream, checked every
// cycle against a pulse-level reference model and a model of the output slot.
module tb_v7_peak_detector;

    localparam int MAXN    = 1600;
    localparam int THR     = 200;
    localparam int HYST    = 16;
    localparam int HOLDOFF = 4;
    localparam int MAXW    = 255;

    typedef struct {
        int amp;
        int tm;
        int width;
        int flags;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] filter_data;
    logic [15:0] threshold;
    logic        peak_valid;
    logic        peak_ready;
    logic [15:0] peak_amp;
    logic [31:0] peak_time;
    logic [7:0]  peak_width;
    logic [1:0]  peak_flags;
    logic [15:0] lost_count;

    int          s   [MAXN];
    bit          en  [MAXN];
    bit          rdy [MAXN];
    logic [31:0] o_v [MAXN];
    logic [31:0] o_amp [MAXN];
    logic [31:0] o_time [MAXN];
    logic [31:0] o_w [MAXN];
    logic [31:0] o_f [MAXN];
    logic [31:0] o_lost [MAXN];
    int          ev_idx [MAXN];
    ev_t         evq[$];
    int          rq[$];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    v7_peak_detector #(
        .SIZE_FILTER_DATA(16), .TS_W(32), .HYST(HYST), .HOLDOFF(HOLDOFF), .MAX_WIDTH(MAXW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .filter_data(filter_data),
        .threshold(threshold), .peak_valid(peak_valid), .peak_ready(peak_ready),
        .peak_amp(peak_amp), .peak_time(peak_time), .peak_width(peak_width),
        .peak_flags(peak_flags), .lost_count(lost_count)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Enable seen by the detector while it judges sample j (driven one step later).
    function automatic bit ev_en(int j, int n);
        if (j + 1 < n) return en[j + 1];
        return 1'b1;
    endfunction

    // Pulse-level reference: walk the sample record, find pulses and the edge of each emission.
    function automatic void scan(int n);
        int k, allowed, j, mx, mt, w, fl, mn, e;
        bit falling, done, disc;
        evq.delete();
        for (int t = 0; t < MAXN; t++) ev_idx[t] = -1;
        k = 0;
        allowed = 0;
        while (k < n) begin
            if (k >= allowed && ((k == 0) ? 0 : s[k-1]) <= THR && s[k] > THR && ev_en(k, n)) begin
                mx = s[k]; mt = k; w = 1; fl = 0; mn = 0;
                falling = 0; done = 0; disc = 0; e = n; j = k + 1;
                while (!done && !disc && j < n) begin
                    if (!ev_en(j, n)) disc = 1;
                    else if (s[j] <= THR) begin e = j; done = 1; end
                    else begin
                        if (s[j] > mx) begin mx = s[j]; mt = j; end
                        w++;
                        if (!falling) begin
                            if (s[j] <= mx - HYST) begin falling = 1; mn = s[j]; end
                        end else if (s[j] >= mn + HYST) begin
                            fl = fl | 1; falling = 0;
                        end else if (s[j] < mn) mn = s[j];
                        if (w == MAXW) begin fl = fl | 2; e = j; done = 1; end
                    end
                    if (!done && !disc) j++;
                end
                if (disc) begin allowed = j + 1; k = j + 1; end
                else if (!done) k = n;
                else if (!ev_en(e + 1, n)) begin allowed = e + 2; k = e + 2; end
                else begin
                    if (e + 2 < n) begin
                        ev_idx[e + 2] = evq.size();
                        evq.push_back('{amp: mx, tm: mt, width: w, flags: fl});
                    end
                    allowed = e + 2 + HOLDOFF;
                    for (int m = e + 1 + HOLDOFF; m >= e + 2; m--)
                        if (!ev_en(m, n)) allowed = m + 1;
                    k = allowed;
                end
            end else k++;
        end
    endfunction

    // Output-slot model driven by the scanned events, compared every cycle.
    task automatic model_check(int n);
        int mv, ma, mt, mw, mf, ml;
        scan(n);
        mv = 0; ma = 0; mt = 0; mw = 0; mf = 0; ml = 0;
        for (int t = 0; t < n; t++) begin
            if (ev_idx[t] >= 0) begin
                if (mv == 0 || rdy[t]) begin
                    mv = 1;
                    ma = evq[ev_idx[t]].amp;   mt = evq[ev_idx[t]].tm;
                    mw = evq[ev_idx[t]].width; mf = evq[ev_idx[t]].flags;
                end else if (ml < 65535) ml++;
            end else if (mv == 1 && rdy[t]) mv = 0;
            check_vec("valid", o_v[t], mv);
            check_vec("amp", o_amp[t], ma);
            check_vec("time", o_time[t], mt);
            check_vec("width", o_w[t], mw);
            check_vec("flags", o_f[t], mf);
            check_vec("lost", o_lost[t], ml);
        end
    endtask

    task automatic clear_phase(int n);
        for (int i = 0; i < n; i++) begin s[i] = 0; en[i] = 1'b1; rdy[i] = 1'b1; end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b1;
            filter_data = 16'($urandom);
            enable = 1'($urandom);
            peak_ready = 1'($urandom);
        end
        @(posedge clk);
        #1;
        check_vec("rst_valid", 32'(peak_valid), 32'd0);
        check_vec("rst_amp", 32'(peak_amp), 32'd0);
        check_vec("rst_time", peak_time, 32'd0);
        check_vec("rst_width", 32'(peak_width), 32'd0);
        check_vec("rst_flags", 32'(peak_flags), 32'd0);
        check_vec("rst_lost", 32'(lost_count), 32'd0);
    endtask

    task automatic run_phase(int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            reset = 1'b0;
            filter_data = 16'(s[k]);
            enable = en[k];
            peak_ready = rdy[k];
            @(posedge clk);
            #1;
            o_v[k] = 32'(peak_valid);
            o_amp[k] = {{16{peak_amp[15]}}, peak_amp};
            o_time[k] = peak_time;
            o_w[k] = 32'(peak_width);
            o_f[k] = 32'(peak_flags);
            o_lost[k] = 32'(lost_count);
        end
        model_check(n);
    endtask

    function automatic void collect_rises(int n);
        rq.delete();
        for (int t = 0; t < n; t++)
            if (o_v[t] === 32'd1 && (t == 0 || o_v[t-1] !== 32'd1)) rq.push_back(t);
    endfunction

    initial begin
        int cur, tgt, acc_n, acc_amp;
        reset = 1'b1; enable = 1'b1; filter_data = 16'd0; peak_ready = 1'b1;
        threshold = 16'(THR);

        // Single pulse
        clear_phase(20);
        s[1] = 100; s[2] = 300; s[3] = 500; s[4] = 400; s[5] = 250; s[6] = 150;
        do_reset();
        run_phase(20);
        collect_rises(20);
        check_vec("single_count", rq.size(), 1);
        if (rq.size() > 0) begin
            check_vec("single_edge", rq[0], 8);
            check_vec("single_amp", o_amp[rq[0]], 500);
            check_vec("single_width", o_w[rq[0]], 4);
            check_vec("single_flags", o_f[rq[0]], 0);
            check_vec("single_time", o_time[rq[0]], 3);
            check_vec("single_1cyc", o_v[rq[0] + 1], 0);
        end

        // Pile-up
        clear_phase(20);
        s[1] = 300; s[2] = 500; s[3] = 450; s[4] = 480; s[5] = 600; s[6] = 100;
        do_reset();
        run_phase(20);
        collect_rises(20);
        check_vec("pile_count", rq.size(), 1);
        if (rq.size() > 0) begin
            check_vec("pile_amp", o_amp[rq[0]], 600);
            check_vec("pile_width", o_w[rq[0]], 5);
            check_vec("pile_flags", o_f[rq[0]], 1);
            check_vec("pile_time", o_time[rq[0]], 5);
        end

        // Backpressure: two pulses while the consumer stalls
        clear_phase(40);
        s[1] = 300; s[2] = 500; s[3] = 300;
        s[12] = 300; s[13] = 700; s[14] = 300;
        for (int i = 0; i < 25; i++) rdy[i] = 1'b0;
        do_reset();
        run_phase(40);
        acc_n = 0; acc_amp = 0;
        for (int t = 1; t < 40; t++)
            if (o_v[t-1] === 32'd1 && rdy[t]) begin acc_n++; acc_amp = int'(o_amp[t-1]); end
        check_vec("bp_lost", o_lost[39], 1);
        check_vec("bp_held_amp", o_amp[24], 500);
        check_vec("bp_accepts", acc_n, 1);
        check_vec("bp_acc_amp", acc_amp, 500);
        check_vec("bp_valid_end", o_v[39], 0);

        // Timeout on a long flat pulse
        clear_phase(320);
        for (int i = 1; i <= 300; i++) s[i] = 1000;
        do_reset();
        run_phase(320);
        collect_rises(320);
        check_vec("to_count", rq.size(), 1);
        if (rq.size() > 0) begin
            check_vec("to_width", o_w[rq[0]], 255);
            check_vec("to_flags", o_f[rq[0]], 2);
            check_vec("to_amp", o_amp[rq[0]], 1000);
            check_vec("to_time", o_time[rq[0]], 1);
        end

        // Randomized stream with random stalls and occasional enable drops
        clear_phase(1500);
        cur = 0; tgt = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) tgt = int'($urandom_range(0, 1700)) - 400;
            cur = cur + (tgt - cur) / 3 + int'($urandom_range(0, 40)) - 20;
            s[i] = cur;
            en[i] = ($urandom_range(0, 63) != 0);
            rdy[i] = ($urandom_range(0, 3) != 0);
        end
        do_reset();
        run_phase(1500);

        // Enable drop, negative samples, retrigger right after holdoff
        clear_phase(50);
        s[1] = 300; s[2] = 500; s[3] = 400;
        en[3] = 1'b0;
        for (int i = 10; i < 30; i++) s[i] = -int'($urandom_range(1, 5000));
        s[15] = -5000;
        s[32] = 300; s[36] = 300; s[39] = 250;
        do_reset();
        run_phase(50);
        collect_rises(50);
        check_vec("en_count", rq.size(), 2);
        if (rq.size() > 1) begin
            check_vec("en_first_amp", o_amp[rq[0]], 300);
            check_vec("en_retrig_amp", o_amp[rq[1]], 250);
            check_vec("en_retrig_time", o_time[rq[1]], 39);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
